// File: rtl/mpu_frame_tx.sv
// MPU response frame transmitter.
// Streams header (MAC DST/SRC, EtherType, type, rows, cols), the optional result
// matrix payload (big-endian elements, row-major) and zero padding up to MIN_FRAME
// bytes over a valid/ready byte interface. The MAC appends the FCS.
module mpu_frame_tx #(
  parameter int unsigned ACC_SIZE    = 24,
  parameter int unsigned MATRIX_SIZE = 10,
  parameter logic [47:0] MAC_SRC     = 48'h5044332211EE,
  parameter logic [47:0] MAC_DST     = 48'hDC0EA1F0573B,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MIN_FRAME   = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          frame_type,
  input  logic [7:0]          rows,
  input  logic [7:0]          cols,
  output logic                busy,
  output logic                done,
  input  logic [ACC_SIZE-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_last
);

  localparam int unsigned NB      = ACC_SIZE / 8;
  localparam int unsigned SHW     = $clog2(NB + 1);
  localparam int unsigned HDR_LEN = 17;

  // Frame type codes: 0 none, 1 data, 2 bad command, 3 bad dimensions, 4 bad frame.
  localparam logic [2:0] FRAME_NONE    = 3'd0;
  localparam logic [2:0] FRAME_DATA    = 3'd1;
  localparam logic [2:0] FRAME_ERR_DIM = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PAD} state_e;

  state_e                state_q, state_d;
  logic [2:0]            ftype_q, ftype_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic [6:0]            total_q, total_d;
  logic [6:0]            elem_cnt_q, elem_cnt_d;
  logic [8:0]            byte_cnt_q, byte_cnt_d;
  logic [ACC_SIZE-1:0]   shreg_q, shreg_d;
  logic [SHW-1:0]        sh_cnt_q, sh_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  data_ready_q, data_ready_d;

  logic [HDR_LEN*8-1:0]  hdr_vec;
  logic [7:0]            hdr_byte;
  logic                  dim_ok;
  logic                  tx_hs, tx_free, data_hs, fin;

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_ready = data_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;

  // Header byte selected by the byte counter (byte 0 is loaded directly at start).
  always_comb begin
    hdr_vec  = {MAC_DST, MAC_SRC, ETHERTYPE, 5'b0, ftype_q, rows_q, cols_q};
    hdr_byte = '0;
    for (int unsigned i = 0; i < HDR_LEN; i++) begin
      if (byte_cnt_q == 9'(i)) hdr_byte = hdr_vec[(HDR_LEN-1-i)*8 +: 8];
    end
  end

  // Frame sequencing, output byte register and element shift register.
  always_comb begin
    state_d    = state_q;
    ftype_d    = ftype_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    total_d    = total_q;
    elem_cnt_d = elem_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    sh_cnt_d   = sh_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fin        = 1'b0;

    tx_hs   = tx_valid_q && tx_ready;
    tx_free = !tx_valid_q || tx_ready;
    data_hs = data_valid && data_ready_q;
    dim_ok  = (rows != 8'd0) && (rows <= 8'(MATRIX_SIZE)) &&
              (cols != 8'd0) && (cols <= 8'(MATRIX_SIZE));

    if (tx_hs && tx_last_q) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      tx_data_d  = '0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && frame_type != FRAME_NONE) begin
            state_d    = S_HEADER;
            busy_d     = 1'b1;
            elem_cnt_d = '0;
            sh_cnt_d   = '0;
            byte_cnt_d = 9'd1;
            tx_data_d  = MAC_DST[47:40];
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            if (frame_type == FRAME_DATA && dim_ok) begin
              ftype_d = FRAME_DATA;
              rows_d  = rows;
              cols_d  = cols;
              total_d = 7'(rows * cols);
            end else begin
              ftype_d = (frame_type == FRAME_DATA) ? FRAME_ERR_DIM : frame_type;
              rows_d  = '0;
              cols_d  = '0;
              total_d = '0;
            end
          end
        end

        S_HEADER: begin
          if (tx_hs) begin
            if (byte_cnt_q < 9'(HDR_LEN)) begin
              tx_data_d  = hdr_byte;
              byte_cnt_d = byte_cnt_q + 9'd1;
              tx_last_d  = (byte_cnt_q == 9'(HDR_LEN-1)) && (ftype_q != FRAME_DATA) &&
                           (HDR_LEN >= MIN_FRAME);
            end else if (ftype_q == FRAME_DATA) begin
              state_d    = S_PAYLOAD;
              tx_valid_d = 1'b0;
            end else begin
              state_d    = S_PAD;
              tx_data_d  = '0;
              byte_cnt_d = byte_cnt_q + 9'd1;
              tx_last_d  = (byte_cnt_q >= 9'(MIN_FRAME-1));
            end
          end
        end

        S_PAYLOAD: begin
          if (tx_free) begin
            if (sh_cnt_q != '0) begin
              tx_data_d  = shreg_q[ACC_SIZE-1 -: 8];
              shreg_d    = shreg_q << 8;
              sh_cnt_d   = sh_cnt_q - SHW'(1);
              fin        = (elem_cnt_q == total_q) && (sh_cnt_q == SHW'(1));
              tx_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q + 9'd1;
              tx_last_d  = fin && (byte_cnt_q >= 9'(MIN_FRAME-1));
            end else if (data_hs) begin
              // Output register is free: first byte bypasses the shift register so
              // back-to-back elements stream without a bubble.
              tx_data_d  = data_in[ACC_SIZE-1 -: 8];
              shreg_d    = data_in << 8;
              sh_cnt_d   = SHW'(NB - 1);
              elem_cnt_d = elem_cnt_q + 7'd1;
              fin        = (elem_cnt_q + 7'd1 == total_q) && (NB == 1);
              tx_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q + 9'd1;
              tx_last_d  = fin && (byte_cnt_q >= 9'(MIN_FRAME-1));
            end else if (elem_cnt_q == total_q && tx_valid_q) begin
              state_d    = S_PAD;
              tx_data_d  = '0;
              byte_cnt_d = byte_cnt_q + 9'd1;
              tx_last_d  = (byte_cnt_q >= 9'(MIN_FRAME-1));
            end else begin
              tx_valid_d = 1'b0;
            end
          end else if (data_hs) begin
            shreg_d    = data_in;
            sh_cnt_d   = SHW'(NB);
            elem_cnt_d = elem_cnt_q + 7'd1;
          end
        end

        S_PAD: begin
          if (tx_hs) begin
            tx_data_d  = '0;
            byte_cnt_d = byte_cnt_q + 9'd1;
            tx_last_d  = (byte_cnt_q >= 9'(MIN_FRAME-1));
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    data_ready_d = (state_d == S_PAYLOAD) && (sh_cnt_d == '0) && (elem_cnt_d != total_d);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ftype_q      <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      total_q      <= '0;
      elem_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      sh_cnt_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ftype_q      <= ftype_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      total_q      <= total_d;
      elem_cnt_q   <= elem_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shreg_q      <= shreg_d;
      sh_cnt_q     <= sh_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      data_ready_q <= data_ready_d;
    end
  end

endmodule

// File: tb/tb_mpu_frame_tx.sv
// Scoreboard bench for mpu_frame_tx: a frame-level model pushes expected bytes,
// an element feeder supplies matrix data, and a monitor checks every accepted byte.
module tb_mpu_frame_tx;

  localparam int          ACC  = 24;
  localparam int          MSZ  = 10;
  localparam int          MINF = 60;
  localparam logic [47:0] DST  = 48'hDC0EA1F0573B;
  localparam logic [47:0] SRC  = 48'h5044332211EE;
  localparam logic [15:0] ET   = 16'h88B5;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_DATA = 3'd1;
  localparam logic [2:0] F_CMD  = 3'd2;
  localparam logic [2:0] F_DIM  = 3'd3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2:0]     frame_type = '0;
  logic [7:0]     rows = '0;
  logic [7:0]     cols = '0;
  logic           busy, done;
  logic [ACC-1:0] data_in = '0;
  logic           data_valid = 1'b0;
  logic           data_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic           tx_last;

  mpu_frame_tx #(
    .ACC_SIZE(ACC), .MATRIX_SIZE(MSZ), .MAC_SRC(SRC), .MAC_DST(DST),
    .ETHERTYPE(ET), .MIN_FRAME(MINF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_type(frame_type),
    .rows(rows), .cols(cols), .busy(busy), .done(done),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  int             total = 0;
  int             bad   = 0;
  logic [8:0]     exp_q[$];
  logic [ACC-1:0] feed_q[$];
  logic [ACC-1:0] elems[$];
  int             ready_mode   = 0;
  bit             feed_gapless = 1'b1;
  bit             elem_taken   = 1'b0;
  bit             cur_is_data  = 1'b0;
  int             frame_idx    = 0;
  bit             stall_prev   = 1'b0;
  logic [7:0]     prev_data    = '0;
  logic           prev_last    = 1'b0;
  bit             done_due     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame built from the layout rules: header, payload, pad to MINF.
  function automatic void model_frame(input logic [2:0] ft, input logic [7:0] r, input logic [7:0] c);
    logic [7:0]     b[$];
    logic [2:0]     eff;
    logic [7:0]     er, ec;
    logic [47:0]    d, s;
    logic [15:0]    e;
    logic [ACC-1:0] el;
    eff = ft; er = r; ec = c; d = DST; s = SRC; e = ET;
    if (ft == F_DATA && (r == 0 || r > MSZ || c == 0 || c > MSZ)) eff = F_DIM;
    if (eff != F_DATA) begin er = '0; ec = '0; end
    for (int i = 0; i < 6; i++) b.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(s[47-8*i -: 8]);
    b.push_back(e[15:8]);
    b.push_back(e[7:0]);
    b.push_back({5'b0, eff});
    b.push_back(er);
    b.push_back(ec);
    if (eff == F_DATA) begin
      for (int k = 0; k < int'(er) * int'(ec); k++) begin
        el = elems[k];
        for (int j = 0; j < ACC/8; j++) b.push_back(el[ACC-1-8*j -: 8]);
        feed_q.push_back(el);
      end
    end
    while (b.size() < MINF) b.push_back(8'h00);
    for (int i = 0; i < b.size(); i++) exp_q.push_back({(i == b.size() - 1), b[i]});
    cur_is_data = (eff == F_DATA);
  endfunction

  task automatic fill_elems(input int n);
    elems.delete();
    repeat (n) elems.push_back(ACC'($urandom()));
  endtask

  task automatic flush();
    exp_q.delete();
    feed_q.delete();
    elem_taken  = 1'b0;
    frame_idx   = 0;
    stall_prev  = 1'b0;
    done_due    = 1'b0;
    data_valid  = 1'b0;
    cur_is_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL timeout: outstanding=%0d busy=%0b required idle", exp_q.size(), busy);
      flush();
    end
  endtask

  task automatic send_frame(input logic [2:0] ft, input logic [7:0] r, input logic [7:0] c);
    wait_idle(4000);
    @(posedge clk); #1;
    start = 1'b1; frame_type = ft; rows = r; cols = c;
    if (ft != F_NONE) model_frame(ft, r, c);
    @(posedge clk); #1;
    start = 1'b0;
    frame_type = 3'($urandom()); rows = 8'($urandom()); cols = 8'($urandom());
    if (ft == F_NONE) check("none_ignored", {busy, tx_valid}, 2'b00);
    else check("start_latency", {busy, tx_valid}, 2'b11);
  endtask

  // Sink readiness patterns.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Element source: presents the head of feed_q, optionally with idle gaps.
  initial forever begin
    @(posedge clk); #1;
    if (elem_taken) begin
      if (feed_q.size() > 0) void'(feed_q.pop_front());
      elem_taken = 1'b0;
    end
    if (feed_q.size() > 0 && (feed_gapless || $urandom_range(0, 3) != 0)) begin
      data_valid = 1'b1;
      data_in    = feed_q[0];
    end else begin
      data_valid = 1'b0;
      data_in    = '0;
    end
  end

  // Monitor: compares accepted bytes against the scoreboard, plus hold/done rules.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!rst) begin
      if (stall_prev) check("hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
      check("done", done, done_due);
      if (done_due) check("busy_at_done", busy, 0);
      if (!cur_is_data) check("no_data_ready", data_ready, 0);
      elem_taken = data_valid && data_ready;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", {tx_last, tx_data});
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", frame_idx), {tx_last, tx_data}, e);
          frame_idx++;
          if (e[8]) frame_idx = 0;
        end
      end
      done_due   = tx_valid && tx_ready && tx_last;
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    int         n;
    logic [2:0] ft;
    logic [7:0] r, c;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_valid, tx_last, tx_data, busy, done, data_ready}, 0);
    rst = 1'b0;

    ready_mode = 0;
    send_frame(F_CMD, 8'd5, 8'd7);

    elems = {24'h000001, 24'hFFFFFF, 24'h123456, 24'h7FFFFF};
    send_frame(F_DATA, 8'd2, 8'd2);

    ready_mode = 1;
    fill_elems(100);
    send_frame(F_DATA, 8'd10, 8'd10);

    ready_mode = 0;
    send_frame(F_DATA, 8'd11, 8'd3);

    send_frame(F_NONE, 8'd2, 8'd2);
    ready_mode = 2;
    feed_gapless = 1'b0;
    fill_elems(6);
    send_frame(F_DATA, 8'd2, 8'd3);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; frame_type = F_CMD; rows = 8'd1; cols = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_during_ignored_start", busy, 1);

    ready_mode = 0;
    feed_gapless = 1'b1;
    fill_elems(100);
    send_frame(F_DATA, 8'd10, 8'd10);
    n = 0;
    while (frame_idx < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte20", (frame_idx >= 20), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_midframe", {tx_valid, tx_last, tx_data, busy, done, data_ready}, 0);
    flush();
    @(posedge clk); #3;
    rst = 1'b0;
    send_frame(F_DIM, 8'd4, 8'd4);

    repeat (25) begin
      ready_mode   = $urandom_range(0, 2);
      feed_gapless = 1'($urandom_range(0, 1));
      r  = 8'($urandom_range(0, 12));
      c  = 8'($urandom_range(0, 12));
      ft = 3'($urandom_range(0, 4));
      fill_elems(int'(r) * int'(c));
      send_frame(ft, r, c);
    end

    wait_idle(4000);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
